// File: rtl/raster_pkg.sv
// Shared types and constants for the raster pattern source.
// Contents: FSM state enum, pattern mode enum, LFSR seed and tap mask.
package raster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_VBLK   = 2'd2
    } raster_state_t;

    typedef enum logic [1:0] {
        MODE_HRAMP   = 2'd0,
        MODE_VRAMP   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_LFSR    = 2'd3
    } raster_mode_t;

    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    // Taps 16,14,13,11 of a right-shifting Fibonacci register map to bits 0,2,3,5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/raster_lfsr.sv
// 16-bit Fibonacci LFSR used as the pseudo-random pixel source.
// Ports:
//   clk, rst_b : clock, synchronous active-low reset (state reloads the seed)
//   load_i     : restart the sequence from the seed this cycle
//   adv_i      : consume the current value and step to the next one
//   pix_c      : value consumed this cycle (combinational, low DW bits)
module raster_lfsr
    import raster_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          load_i,
    input  logic          adv_i,
    output logic [DW-1:0] pix_c
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] cur_c;
    logic [LFSR_W-1:0] step_c;

    // A load presents the seed in the same cycle so the first frame pixel sees it.
    always_comb begin
        cur_c  = load_i ? LFSR_SEED : lfsr_q;
        step_c = {^(cur_c & LFSR_TAPS), cur_c[LFSR_W-1:1]};
        lfsr_d = adv_i ? step_c : cur_c;
        pix_c  = DW'(cur_c);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/raster_stream_gen.sv
// Raster video test-pattern source with programmable active/blanking geometry.
// Ports:
//   clk, rst_b  : pixel clock, synchronous active-low reset
//   en          : frame request, honoured in IDLE and on the last blanking cycle
//   mode        : pattern select (H-ramp, V-ramp, checker, LFSR), latched per frame
//   vvalid      : high through every active line including its horizontal blanking
//   hvalid      : high on active pixels
//   dout        : pixel data, zero outside active pixels
//   busy        : high while a frame is in progress
//   frame_done  : one-cycle pulse on the last blanking cycle of a frame
module raster_stream_gen
    import raster_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned HACT     = 1920,
    parameter int unsigned HBLANK   = 280,
    parameter int unsigned VACT     = 1080,
    parameter int unsigned VBLANK   = 45,
    parameter int unsigned CW       = 12,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          en,
    input  logic [1:0]    mode,
    output logic          vvalid,
    output logic          hvalid,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned HTOT = HACT + HBLANK;
    localparam int unsigned VTOT = VACT + VBLANK;

    localparam logic [CW-1:0] X_LAST     = CW'(HTOT - 1);
    localparam logic [CW-1:0] X_ACT      = CW'(HACT);
    localparam logic [CW-1:0] Y_ACT_LAST = CW'(VACT - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(VTOT - 1);

    raster_state_t state_q, state_d;
    raster_mode_t  mode_q, mode_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          start_c;

    logic          vvalid_q, vvalid_d;
    logic          hvalid_q, hvalid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] lfsr_pix_c;

    raster_lfsr #(
        .DW (DW)
    ) u_lfsr (
        .clk    (clk),
        .rst_b  (rst_b),
        .load_i (start_c),
        .adv_i  (hvalid_d),
        .pix_c  (lfsr_pix_c)
    );

    // Next position and the registered outputs that describe it; x/y/state
    // always hold the position currently presented on the outputs.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                x_d = '0;
                y_d = '0;
                if (en) begin
                    state_d = ST_ACTIVE;
                    mode_d  = raster_mode_t'(mode);
                    start_c = 1'b1;
                end
            end
            ST_ACTIVE, ST_VBLK: begin
                if (x_q != X_LAST) begin
                    x_d = x_q + CW'(1);
                end else begin
                    x_d = '0;
                    y_d = y_q + CW'(1);
                    if (state_q == ST_ACTIVE && y_q == Y_ACT_LAST) begin
                        state_d = ST_VBLK;
                    end else if (state_q == ST_VBLK && y_q == Y_LAST) begin
                        y_d = '0;
                        if (en) begin
                            state_d = ST_ACTIVE;
                            mode_d  = raster_mode_t'(mode);
                            start_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = '0;
                y_d     = '0;
            end
        endcase

        vvalid_d     = (state_d == ST_ACTIVE);
        hvalid_d     = vvalid_d && (x_d < X_ACT);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_VBLK) && (x_d == X_LAST) && (y_d == Y_LAST);

        dout_d = '0;
        if (hvalid_d) begin
            case (mode_d)
                MODE_HRAMP:   dout_d = DW'(x_d);
                MODE_VRAMP:   dout_d = DW'(y_d);
                MODE_CHECKER: dout_d = {DW{x_d[CHK_LOG2] ^ y_d[CHK_LOG2]}};
                MODE_LFSR:    dout_d = lfsr_pix_c;
            endcase
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_HRAMP;
            x_q          <= '0;
            y_q          <= '0;
            vvalid_q     <= 1'b0;
            hvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vvalid_q     <= vvalid_d;
            hvalid_q     <= hvalid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            dout_q       <= dout_d;
        end
    end

    assign vvalid     = vvalid_q;
    assign hvalid     = hvalid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign dout       = dout_q;

endmodule
